// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types and constants for the 5-stage MIPS pipeline.
//            ctrl_t field order (MSB..LSB):
//            {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst,
//             alu_op[2:0], branch}
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int AOPW = 3;

  // Register 0 is hardwired to zero and never carries a real dependency.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [AOPW-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_detect_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect_unit
// Purpose  : Combinational load-use hazard detection between EX and ID.
// Ports    : ex_valid, ex_mem_read, ex_rt       - load currently in EX
//            id_valid, id_rs, id_rt, id_uses_*  - instruction in ID
//            flush                              - ID instruction squashed
//            hazard                             - load-use dependency present
//            stall                              - freeze PC and IF/ID
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect_unit
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic          flush,
  output logic          hazard,
  output logic          stall
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_rt);
    rt_match = id_uses_rt && (id_rt == ex_rt);
    hazard   = ex_valid && ex_mem_read && (ex_rt != RW'(REG_ZERO)) &&
               id_valid && (rs_match || rt_match);
    // A flushed dependent instruction is discarded anyway, so no freeze.
    stall    = hazard && !flush;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard stall generation.
//            Flush or hazard turns the EX slot into a bubble (ctrl all-zero).
// Ports    : clk, rst (async, active-high)
//            id_*   - decoded instruction from ID
//            flush  - squash the ID instruction
//            stall  - combinational freeze request for PC and IF/ID
//            ex_*   - registered instruction presented to EX
//            ex_stall_cnt - stall cycle counter (only with STALL_CNT_EN)
// Config   : `define STALL_CNT_EN to add the ex_stall_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  ctrl_t         id_ctrl,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
`ifdef STALL_CNT_EN
  output logic [31:0]   ex_stall_cnt,
`endif
  output ctrl_t         ex_ctrl
);

  logic          ex_valid_q,  ex_valid_d;
  logic [RW-1:0] ex_rs_q,     ex_rs_d;
  logic [RW-1:0] ex_rt_q,     ex_rt_d;
  logic [RW-1:0] ex_rd_q,     ex_rd_d;
  logic [DW-1:0] ex_rdata1_q, ex_rdata1_d;
  logic [DW-1:0] ex_rdata2_q, ex_rdata2_d;
  logic [DW-1:0] ex_imm_q,    ex_imm_d;
  ctrl_t         ex_ctrl_q,   ex_ctrl_d;
  logic          hazard;
  logic          bubble;

  hazard_detect_unit #(
    .RW (RW)
  ) u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rt       (ex_rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .flush       (flush),
    .hazard      (hazard),
    .stall       (stall)
  );

  always_comb begin
    bubble      = flush || hazard;
    // Data and index fields always follow ID so bubbles stay deterministic.
    ex_rs_d     = id_rs;
    ex_rt_d     = id_rt;
    ex_rd_d     = id_rd;
    ex_rdata1_d = id_rdata1;
    ex_rdata2_d = id_rdata2;
    ex_imm_d    = id_imm;
    ex_valid_d  = id_valid && !bubble;
    ex_ctrl_d   = ex_valid_d ? id_ctrl : CTRL_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= CTRL_BUBBLE;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      ex_rdata1_q <= ex_rdata1_d;
      ex_rdata2_q <= ex_rdata2_d;
      ex_imm_q    <= ex_imm_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Natural 32-bit wrap from 0xFFFFFFFF to 0.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_stall_cnt = stall_cnt_q;
`endif

  assign ex_valid  = ex_valid_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rdata1 = ex_rdata1_q;
  assign ex_rdata2 = ex_rdata2_q;
  assign ex_imm    = ex_imm_q;
  assign ex_ctrl   = ex_ctrl_q;

endmodule
`default_nettype wire
